// File: rtl/usb_buffer_controller.sv
// ----------------------------------------------------------------------------
// usb_buffer_controller: packet sequencer and access arbiter for the endpoint
// data buffer (USB RX/TX side versus host side).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module usb_buffer_controller #(
  parameter int MAX_BYTES  = 64,
  parameter int RX_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_rx_packet_start,
  input  logic       i_rx_byte_valid,
  input  logic       i_rx_packet_done,
  input  logic       i_rx_error,
  input  logic       i_tx_start_req,
  input  logic       i_tx_byte_req,
  input  logic       i_tx_done,
  input  logic       i_host_wr_req,
  input  logic       i_host_rd_req,
  input  logic [1:0] i_host_size,
  input  logic       i_host_clear,
  input  logic [6:0] i_buffer_occupancy,
  output logic       o_store_rx_packet_data,
  output logic       o_get_tx_packet_data,
  output logic       o_store_tx_data,
  output logic       o_get_rx_data,
  output logic       o_clear,
  output logic       o_buffer_reserved,
  output logic [1:0] o_data_size,
  output logic       o_host_ack,
  output logic       o_host_err,
  output logic       o_rx_data_ready,
  output logic       o_tx_busy,
  output logic       o_rx_nak,
  output logic       o_overflow_err,
  output logic       o_timeout_err
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_rx_active = 3'd1;
  localparam logic [2:0] c_st_rx_hold   = 3'd2;
  localparam logic [2:0] c_st_tx_active = 3'd3;
  localparam logic [2:0] c_st_flush     = 3'd4;

  localparam logic [7:0] c_max_bytes  = 8'(MAX_BYTES);
  localparam logic [7:0] c_rx_timeout = 8'(RX_TIMEOUT);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_ovf;
  logic       r_to;

  logic [2:0] w_next_state;
  logic [7:0] w_next_cnt;
  logic [7:0] w_cnt_inc;
  logic       w_set_ovf;
  logic       w_set_to;
  logic [2:0] w_size;
  logic       w_size_ok;
  logic       w_wr_fit;
  logic       w_rd_ok;
  logic       w_full;
  logic       w_occ_nz;

  always_comb begin
    case (i_host_size)
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      2'b10:   w_size = 3'd4;
      default: w_size = 3'd0;
    endcase
  end

  assign w_size_ok = (i_host_size != 2'b11);
  assign w_wr_fit  = (({1'b0, i_buffer_occupancy} + {5'd0, w_size}) <= c_max_bytes);
  assign w_rd_ok   = (i_buffer_occupancy >= {4'd0, w_size});
  assign w_full    = ({1'b0, i_buffer_occupancy} >= c_max_bytes);
  assign w_occ_nz  = (i_buffer_occupancy != 7'd0);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // Strobes are pure decodes of state and inputs, forced low while in reset.
  always_comb begin
    w_next_state           = r_state;
    w_next_cnt             = r_cnt;
    w_set_ovf              = 1'b0;
    w_set_to               = 1'b0;
    o_store_rx_packet_data = 1'b0;
    o_get_tx_packet_data   = 1'b0;
    o_store_tx_data        = 1'b0;
    o_get_rx_data          = 1'b0;
    o_clear                = 1'b0;
    o_host_ack             = 1'b0;
    o_host_err             = 1'b0;
    o_rx_nak               = 1'b0;
    if (!n_rst) begin
      w_next_state = c_st_idle;
    end else if (i_host_clear) begin
      w_next_state = c_st_flush;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (i_rx_packet_start) begin
            w_next_state = c_st_rx_active;
            w_next_cnt   = 8'd0;
          end else if (i_tx_start_req) begin
            if (w_occ_nz) w_next_state = c_st_tx_active;
            else          o_host_err   = 1'b1;
          end else if (i_host_wr_req) begin
            if (w_size_ok && w_wr_fit) begin
              o_store_tx_data = 1'b1;
              o_host_ack      = 1'b1;
            end else begin
              o_host_err = 1'b1;
            end
          end else if (i_host_rd_req) begin
            if (w_size_ok && w_rd_ok) begin
              o_get_rx_data = 1'b1;
              o_host_ack    = 1'b1;
            end else begin
              o_host_err = 1'b1;
            end
          end
        end
        c_st_rx_active: begin
          if (i_rx_error) begin
            w_next_state = c_st_flush;
          end else if (i_rx_byte_valid) begin
            if (!w_full) begin
              o_store_rx_packet_data = 1'b1;
              w_next_cnt             = 8'd0;
              // The stored byte guarantees a non-empty buffer on done.
              if (i_rx_packet_done) w_next_state = c_st_rx_hold;
            end else begin
              w_set_ovf    = 1'b1;
              w_next_state = c_st_flush;
            end
          end else if (i_rx_packet_done) begin
            w_next_state = w_occ_nz ? c_st_rx_hold : c_st_idle;
          end else begin
            w_next_cnt = w_cnt_inc;
            if (w_cnt_inc >= c_rx_timeout) begin
              w_set_to     = 1'b1;
              w_next_state = c_st_flush;
            end
          end
        end
        c_st_rx_hold: begin
          o_rx_nak = i_rx_packet_start;
          if (i_host_wr_req) begin
            o_host_err = 1'b1;
          end else if (i_host_rd_req) begin
            if (w_size_ok && w_rd_ok) begin
              o_get_rx_data = 1'b1;
              o_host_ack    = 1'b1;
              if (i_buffer_occupancy == {4'd0, w_size}) w_next_state = c_st_idle;
            end else begin
              o_host_err = 1'b1;
            end
          end
        end
        c_st_tx_active: begin
          o_rx_nak             = i_rx_packet_start;
          o_get_tx_packet_data = i_tx_byte_req && w_occ_nz;
          if (i_tx_done) w_next_state = c_st_idle;
        end
        c_st_flush: begin
          o_clear      = 1'b1;
          w_next_state = c_st_idle;
        end
        default: w_next_state = c_st_idle;
      endcase
    end
  end

  assign o_data_size       = (o_store_tx_data || o_get_rx_data) ? i_host_size : 2'b00;
  assign o_buffer_reserved = (r_state == c_st_rx_active) || (r_state == c_st_tx_active);
  assign o_rx_data_ready   = (r_state == c_st_rx_hold);
  assign o_tx_busy         = (r_state == c_st_tx_active);
  assign o_overflow_err    = r_ovf;
  assign o_timeout_err     = r_to;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_st_idle;
      r_cnt   <= 8'd0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (i_host_clear) begin
        r_ovf <= 1'b0;
        r_to  <= 1'b0;
      end else begin
        if (w_set_ovf) r_ovf <= 1'b1;
        if (w_set_to)  r_to  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_buffer_controller.sv
// ----------------------------------------------------------------------------
// tb_usb_buffer_controller: directed vectors with a per-cycle expected-output
// queue drained by an independent negedge monitor.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_usb_buffer_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_packet_start, rx_byte_valid, rx_packet_done, rx_error;
  logic       tx_start_req, tx_byte_req, tx_done;
  logic       host_wr_req, host_rd_req, host_clear;
  logic [1:0] host_size;
  logic [6:0] occ;

  logic       store_rx, get_tx, store_tx, get_rx, clr, reserved;
  logic [1:0] data_size;
  logic       ack, err, rdy, txb, nak, ovf, tmo;

  // Output bit map:
  // 14 store_rx 13 get_tx 12 store_tx 11 get_rx 10 clear 9 reserved
  // 8:7 data_size 6 ack 5 err 4 rx_ready 3 tx_busy 2 nak 1 ovf 0 timeout
  localparam logic [14:0] c_srx = 15'h4000;
  localparam logic [14:0] c_gtx = 15'h2000;
  localparam logic [14:0] c_stx = 15'h1000;
  localparam logic [14:0] c_grx = 15'h0800;
  localparam logic [14:0] c_clr = 15'h0400;
  localparam logic [14:0] c_res = 15'h0200;
  localparam logic [14:0] c_ds2 = 15'h0100;
  localparam logic [14:0] c_ds1 = 15'h0080;
  localparam logic [14:0] c_ack = 15'h0040;
  localparam logic [14:0] c_err = 15'h0020;
  localparam logic [14:0] c_rdy = 15'h0010;
  localparam logic [14:0] c_txb = 15'h0008;
  localparam logic [14:0] c_nak = 15'h0004;
  localparam logic [14:0] c_ovf = 15'h0002;
  localparam logic [14:0] c_to  = 15'h0001;

  logic [14:0] w_out;
  assign w_out = {store_rx, get_tx, store_tx, get_rx, clr, reserved, data_size,
                  ack, err, rdy, txb, nak, ovf, tmo};

  usb_buffer_controller #(.MAX_BYTES(64), .RX_TIMEOUT(255)) dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .i_rx_packet_start      (rx_packet_start),
    .i_rx_byte_valid        (rx_byte_valid),
    .i_rx_packet_done       (rx_packet_done),
    .i_rx_error             (rx_error),
    .i_tx_start_req         (tx_start_req),
    .i_tx_byte_req          (tx_byte_req),
    .i_tx_done              (tx_done),
    .i_host_wr_req          (host_wr_req),
    .i_host_rd_req          (host_rd_req),
    .i_host_size            (host_size),
    .i_host_clear           (host_clear),
    .i_buffer_occupancy     (occ),
    .o_store_rx_packet_data (store_rx),
    .o_get_tx_packet_data   (get_tx),
    .o_store_tx_data        (store_tx),
    .o_get_rx_data          (get_rx),
    .o_clear                (clr),
    .o_buffer_reserved      (reserved),
    .o_data_size            (data_size),
    .o_host_ack             (ack),
    .o_host_err             (err),
    .o_rx_data_ready        (rdy),
    .o_tx_busy              (txb),
    .o_rx_nak               (nak),
    .o_overflow_err         (ovf),
    .o_timeout_err          (tmo)
  );

  always #5 clk = ~clk;

  logic [14:0] q_exp[$];
  string       q_name[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [14:0] m_exp;
  string       m_name;

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      m_exp  = q_exp.pop_front();
      m_name = q_name.pop_front();
      n_checks++;
      if (w_out !== m_exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", m_name, w_out, m_exp);
      end
    end
  end

  // Inputs are already set for this cycle; pulses drop after the edge.
  task automatic tick(input string nm, input logic chk, input logic [14:0] ex);
    if (chk) begin
      q_exp.push_back(ex);
      q_name.push_back(nm);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rx_packet_start = 0; rx_byte_valid = 0; rx_packet_done = 0; rx_error = 0;
    tx_start_req = 0; tx_byte_req = 0; tx_done = 0;
    host_wr_req = 0; host_rd_req = 0; host_clear = 0;
  endtask

  initial begin
    n_rst = 0; host_size = 2'b00; occ = 7'd0;
    rx_packet_start = 0; rx_byte_valid = 0; rx_packet_done = 0; rx_error = 0;
    tx_start_req = 0; tx_byte_req = 0; tx_done = 0;
    host_wr_req = 0; host_rd_req = 0; host_clear = 0;
    host_wr_req = 1;
    tick("reset", 1, 15'h0);
    n_rst = 1;

    // Reset in the middle of a receive
    rx_packet_start = 1; tick("rx_start", 1, 15'h0);
    for (int i = 0; i < 5; i++) begin
      occ = 7'(i); rx_byte_valid = 1; tick("rx_store5", 1, c_srx | c_res);
    end
    occ = 7'd5; n_rst = 0; rx_byte_valid = 1; host_wr_req = 1;
    tick("reset_mid_rx", 1, 15'h0);
    n_rst = 1;
    tick("post_reset", 1, 15'h0);
    occ = 7'd0; host_size = 2'b00; host_wr_req = 1;
    tick("idle_after_reset", 1, c_stx | c_ack);

    // Four-byte packet then a 4-byte host read
    rx_packet_start = 1; tick("rx4_start", 1, 15'h0);
    for (int i = 0; i < 4; i++) begin
      occ = 7'(i); rx_byte_valid = 1; tick("rx4_store", 1, c_srx | c_res);
    end
    occ = 7'd4; rx_packet_done = 1; tick("rx4_done", 1, c_res);
    tick("rx4_hold", 1, c_rdy);
    host_size = 2'b10; host_rd_req = 1; tick("rx4_read", 1, c_grx | c_ds2 | c_ack | c_rdy);
    occ = 7'd0; tick("rx4_idle", 1, 15'h0);

    // Byte and done together, then NAK / host checks in RX_HOLD
    rx_packet_start = 1; tick("rx1_start", 1, 15'h0);
    rx_byte_valid = 1; rx_packet_done = 1; tick("rx1_byte_done", 1, c_srx | c_res);
    occ = 7'd1; rx_packet_start = 1; tick("hold_nak", 1, c_rdy | c_nak);
    host_wr_req = 1; tick("hold_write_err", 1, c_rdy | c_err);
    host_size = 2'b01; host_rd_req = 1; tick("hold_read_short", 1, c_rdy | c_err);
    host_size = 2'b00; host_rd_req = 1; tick("hold_read_last", 1, c_grx | c_ack | c_rdy);
    occ = 7'd0; tick("hold_to_idle", 1, 15'h0);

    // Empty packet returns straight to IDLE
    rx_packet_start = 1; tick("rx0_start", 1, 15'h0);
    rx_packet_done = 1; tick("rx0_done", 1, c_res);
    tick("rx0_idle", 1, 15'h0);

    // Overflow and host clear
    occ = 7'd64; rx_packet_start = 1; tick("ovf_start", 1, 15'h0);
    rx_byte_valid = 1; tick("ovf_byte", 1, c_res);
    tick("ovf_flush", 1, c_clr | c_ovf);
    tick("ovf_sticky", 1, c_ovf);
    host_clear = 1; tick("ovf_host_clear", 1, c_ovf);
    tick("ovf_clear_flush", 1, c_clr);
    occ = 7'd0; tick("ovf_cleared", 1, 15'h0);

    // Timeout after 255 byte-less cycles
    rx_packet_start = 1; tick("to_start", 1, 15'h0);
    for (int k = 1; k <= 255; k++) tick("to_wait", 1, c_res);
    tick("to_flush", 1, c_clr | c_to);
    tick("to_sticky", 1, c_to);
    host_clear = 1; tick("to_host_clear", 1, c_to);
    tick("to_clear_flush", 1, c_clr);
    tick("to_cleared", 1, 15'h0);

    // Host writes, boundaries, then transmit
    host_size = 2'b10; occ = 7'd0; host_wr_req = 1; tick("wr4a", 1, c_stx | c_ds2 | c_ack);
    occ = 7'd4; host_wr_req = 1; tick("wr4b", 1, c_stx | c_ds2 | c_ack);
    host_size = 2'b01; occ = 7'd8; host_wr_req = 1; tick("wr2", 1, c_stx | c_ds1 | c_ack);
    occ = 7'd63; host_wr_req = 1; tick("wr_over", 1, c_err);
    occ = 7'd62; host_wr_req = 1; tick("wr_exact_fit", 1, c_stx | c_ds1 | c_ack);
    host_size = 2'b11; occ = 7'd10; host_wr_req = 1; tick("wr_illegal", 1, c_err);
    host_size = 2'b10; occ = 7'd1; host_rd_req = 1; tick("rd_short", 1, c_err);
    occ = 7'd0; tx_start_req = 1; tick("tx_empty", 1, c_err);
    occ = 7'd10; tx_start_req = 1; tick("tx_start", 1, 15'h0);
    for (int i = 10; i > 0; i--) begin
      occ = 7'(i); tx_byte_req = 1; tick("tx_byte", 1, c_gtx | c_res | c_txb);
    end
    occ = 7'd0; tx_byte_req = 1; tick("tx_underrun", 1, c_res | c_txb);
    rx_packet_start = 1; tick("tx_nak", 1, c_res | c_txb | c_nak);
    host_wr_req = 1; tick("tx_host_stall", 1, c_res | c_txb);
    tx_done = 1; tick("tx_done", 1, c_res | c_txb);
    tick("tx_idle", 1, 15'h0);

    // RX start beats a host write; host requests stall in RX_ACTIVE
    host_size = 2'b00; rx_packet_start = 1; host_wr_req = 1; tick("arb_start", 1, 15'h0);
    occ = 7'd5; host_rd_req = 1; tick("arb_rx_stall", 1, c_res);
    rx_error = 1; tick("arb_rx_error", 1, c_res);
    tick("arb_flush", 1, c_clr);
    tick("arb_idle", 1, 15'h0);

    @(negedge clk); #1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
